// File: rtl/spell_mem_arbiter_pkg.sv
// Memory type codes shared by the spell core, the memory and this arbiter.
// The Wishbone window maps address bit 8 onto these two codes.
package spell_mem_arbiter_pkg;
    localparam logic [1:0] MemoryTypeCode = 2'b00;
    localparam logic [1:0] MemoryTypeData = 2'b01;
endpackage

// File: rtl/spell_mem_arbiter_rr2.sv
// Two-way round-robin grant: on a tie the requester that was not served last wins.
// req[0] is the core, req[1] is Wishbone; last = 1 means Wishbone was served last.
module spell_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    assign grant[0] = req[0] & (~req[1] | last);
    assign grant[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/spell_mem_arbiter.sv
// Shares the single spell memory port between the spell core and a Wishbone slave window.
// One locked transaction at a time, ended by mem_data_ready or by the timeout counter.
module spell_mem_arbiter
    import spell_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_select,
    input  logic [7:0]  core_addr,
    input  logic [7:0]  core_data_in,
    input  logic [1:0]  core_type,
    input  logic        core_write,
    output logic [7:0]  core_data_out,
    output logic        core_data_ready,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        mem_select,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_data_in,
    output logic [1:0]  mem_type,
    output logic        mem_write,
    input  logic [7:0]  mem_data_out,
    input  logic        mem_data_ready,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        OOW       = 3'd1,
        BUSY_CORE = 3'd2,
        BUSY_WB   = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic       last_wb;
    logic [7:0] count;
    logic [1:0] grant;
    logic       wb_req;
    logic       wb_in_window;
    logic       done;
    logic [7:0] resp_data;
    logic [1:0] wb_type;
    logic       unused;

    assign wb_req       = i_wb_cyc & i_wb_stb;
    assign wb_in_window = (i_wb_addr[23:9] == 15'd0);
    assign wb_type      = i_wb_addr[8] ? MemoryTypeData : MemoryTypeCode;
    // Ready in the same cycle as the last count wins over the timeout.
    assign done         = mem_data_ready || (count == LAST_COUNT);
    assign resp_data    = mem_data_ready ? mem_data_out : 8'hFF;
    assign unused       = ^{i_wb_data[31:8], i_wb_addr[31:24]};

    spell_arb_rr2 u_rr (
        .req   ({wb_req, core_select}),
        .last  (last_wb),
        .grant (grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            last_wb         <= 1'b1;
            count           <= 8'd0;
            core_data_out   <= 8'd0;
            core_data_ready <= 1'b0;
            o_wb_ack        <= 1'b0;
            o_wb_data       <= 32'd0;
            mem_select      <= 1'b0;
            mem_addr        <= 8'd0;
            mem_data_in     <= 8'd0;
            mem_type        <= 2'd0;
            mem_write       <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            core_data_ready <= 1'b0;
            o_wb_ack        <= 1'b0;
            timeout_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant[1] && !wb_in_window) begin
                        // Out-of-window access is acked with zero data and never reaches memory.
                        state     <= OOW;
                        busy      <= 1'b1;
                        o_wb_ack  <= 1'b1;
                        o_wb_data <= 32'd0;
                    end else if (grant[0]) begin
                        state       <= BUSY_CORE;
                        busy        <= 1'b1;
                        last_wb     <= 1'b0;
                        count       <= 8'd0;
                        mem_select  <= 1'b1;
                        mem_addr    <= core_addr;
                        mem_data_in <= core_data_in;
                        mem_type    <= core_type;
                        mem_write   <= core_write;
                    end else if (grant[1]) begin
                        state       <= BUSY_WB;
                        busy        <= 1'b1;
                        last_wb     <= 1'b1;
                        count       <= 8'd0;
                        mem_select  <= 1'b1;
                        mem_addr    <= i_wb_addr[7:0];
                        mem_data_in <= i_wb_data[7:0];
                        mem_type    <= wb_type;
                        mem_write   <= i_wb_we;
                    end
                end
                OOW: state <= RELEASE;
                BUSY_CORE, BUSY_WB: begin
                    count <= count + 8'd1;
                    if (done) begin
                        state       <= RELEASE;
                        mem_select  <= 1'b0;
                        timeout_err <= ~mem_data_ready;
                        if (state == BUSY_CORE) begin
                            core_data_ready <= 1'b1;
                            core_data_out   <= resp_data;
                        end else begin
                            o_wb_ack  <= 1'b1;
                            o_wb_data <= {24'd0, resp_data};
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
